// File: rtl/lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lock_sequencer
// Function : Digital lock sequencer. Collects BCD digits, compares against a
//            stored code, drives a timed unlock and an optional timed lockout.
//            Lockout is built only when LOCK_SEQUENCER_LOCKOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module lock_sequencer #(
    parameter int DIGITS         = 4,
    parameter int CODE_LENGTH    = 4 * DIGITS,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int UNLOCK_CYCLES  = 250,
    parameter int LOCKOUT_CYCLES = 500
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              key,
    input  logic [3:0]                        digit,
    input  logic [CODE_LENGTH-1:0]            pinCode,
    output logic                              unlock,
    output logic                              lockout,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts,
    output logic [$clog2(DIGITS+1)-1:0]       entryCount
);

    localparam int AW        = $clog2(MAX_ATTEMPTS + 1);
    localparam int EW        = $clog2(DIGITS + 1);
    localparam int TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW        = $clog2(TIMER_MAX + 1);

    localparam logic [EW-1:0] c_last_digit  = EW'(DIGITS - 1);
    localparam logic [AW-1:0] c_max_att     = AW'(MAX_ATTEMPTS);
    localparam logic [TW-1:0] c_unlock_load = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] c_timer_one   = TW'(1);

    localparam logic [1:0] c_READ     = 2'd0;
    localparam logic [1:0] c_CHECK    = 2'd1;
    localparam logic [1:0] c_UNLOCKED = 2'd2;
`ifdef LOCK_SEQUENCER_LOCKOUT_EN
    localparam logic [1:0] c_LOCKOUT  = 2'd3;
    localparam logic [TW-1:0] c_lockout_load = TW'(LOCKOUT_CYCLES);
`endif

    logic [1:0]             r_state;
    logic [1:0]             w_next;
    logic [CODE_LENGTH-1:0] r_entry;
    logic [EW-1:0]          r_count;
    logic [AW-1:0]          r_attempts;
    logic [TW-1:0]          r_timer;
    logic                   r_unlock;
    logic                   r_lockout;

    logic                   w_digit_ok;
    logic                   w_match;
    logic [AW-1:0]          w_att_inc;
    logic [CODE_LENGTH-1:0] w_shifted;
    logic                   w_unlock_d;
    logic                   w_lockout_d;

    assign w_digit_ok = key && (digit <= 4'd9);
    assign w_match    = (r_entry == pinCode);
    assign w_att_inc  = (r_attempts == c_max_att) ? r_attempts : r_attempts + AW'(1);
    assign w_shifted  = CODE_LENGTH'({r_entry, digit});

    // State register plus registered datapath and outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= c_READ;
            r_entry    <= '0;
            r_count    <= '0;
            r_attempts <= '0;
            r_timer    <= '0;
            r_unlock   <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_unlock  <= w_unlock_d;
            r_lockout <= w_lockout_d;
            case (r_state)
                c_READ: begin
                    if (w_digit_ok) begin
                        r_entry <= w_shifted;
                        r_count <= r_count + EW'(1);
                    end
                end
                c_CHECK: begin
                    r_entry <= '0;
                    r_count <= '0;
                    if (w_match) begin
                        r_attempts <= '0;
                        r_timer    <= c_unlock_load;
                    end else begin
                        r_attempts <= w_att_inc;
`ifdef LOCK_SEQUENCER_LOCKOUT_EN
                        if (w_att_inc == c_max_att) begin
                            r_timer <= c_lockout_load;
                        end
`endif
                    end
                end
                c_UNLOCKED: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - c_timer_one;
                    end
                end
`ifdef LOCK_SEQUENCER_LOCKOUT_EN
                c_LOCKOUT: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - c_timer_one;
                    end
                    if (w_next == c_READ) begin
                        r_attempts <= '0;
                    end
                end
`endif
                default: begin
                    r_entry <= '0;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_READ: begin
                if (w_digit_ok && (r_count == c_last_digit)) begin
                    w_next = c_CHECK;
                end
            end
            c_CHECK: begin
                if (w_match) begin
                    w_next = c_UNLOCKED;
                end else begin
`ifdef LOCK_SEQUENCER_LOCKOUT_EN
                    w_next = (w_att_inc == c_max_att) ? c_LOCKOUT : c_READ;
`else
                    w_next = c_READ;
`endif
                end
            end
            c_UNLOCKED: begin
                if (r_timer <= c_timer_one) begin
                    w_next = c_READ;
                end
            end
`ifdef LOCK_SEQUENCER_LOCKOUT_EN
            c_LOCKOUT: begin
                if (r_timer <= c_timer_one) begin
                    w_next = c_READ;
                end
            end
`endif
            default: w_next = c_READ;
        endcase
    end

    // Output decode, registered one cycle later to give the two-cycle unlock latency
    always_comb begin
        w_unlock_d  = (r_state == c_UNLOCKED);
`ifdef LOCK_SEQUENCER_LOCKOUT_EN
        w_lockout_d = (r_state == c_LOCKOUT);
`else
        w_lockout_d = 1'b0;
`endif
    end

    assign unlock     = r_unlock;
    assign lockout    = r_lockout;
    assign attempts   = r_attempts;
    assign entryCount = r_count;

endmodule
`default_nettype wire
